// File: rtl/irq_controller_multi_if.sv
// Bundle of request-side inputs and trap-side outputs of irq_controller_multi.
//   master : the CPU/peripheral side, drives requests, masks, enables, exception and MRET
//   slave  : the interrupt controller, returns trap entry, cause, return pulse and line ack
// Clock and reset are kept as plain ports on the controller, not in this bundle.
interface irq_controller_multi_if #(
  parameter int N_IRQ = 16
);
  logic             exception_i;
  logic [N_IRQ-1:0] irq_req_i;
  logic [N_IRQ-1:0] irq_mask_i;
  logic             mie_i;
  logic             mret_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic             irq_ret_o;
  logic [N_IRQ-1:0] irq_ack_o;

  modport master (
    output exception_i, irq_req_i, irq_mask_i, mie_i, mret_i,
    input  irq_o, irq_cause_o, irq_ret_o, irq_ack_o
  );

  modport slave (
    input  exception_i, irq_req_i, irq_mask_i, mie_i, mret_i,
    output irq_o, irq_cause_o, irq_ret_o, irq_ack_o
  );
endinterface

// File: rtl/irq_controller_multi.sv
// Multi-line machine-mode interrupt controller.
// Arbitrates N_IRQ request lines (per-line mask, per-line edge/level mode,
// fixed priority with line 0 highest), raises trap entry and mcause, keeps
// exceptions ahead of interrupts and returns from the handler on MRET.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : irq_controller_multi_if.slave
//            in : exception_i, irq_req_i, irq_mask_i, mie_i, mret_i
//            out: irq_o (take pulse), irq_cause_o, irq_ret_o (return pulse),
//                 irq_ack_o (one-hot serviced line, with irq_ret_o)
module irq_controller_multi #(
  parameter int               N_IRQ      = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  parameter int               CAUSE_BASE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  irq_controller_multi_if.slave bus
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IRQ     = 2'd1,
    ST_EXC     = 2'd2,
    ST_IRQ_EXC = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] req_q, req_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_IRQ-1:0] rise_s;
  logic [N_IRQ-1:0] eff_s;
  logic [N_IRQ-1:0] cand_s;
  logic [N_IRQ-1:0] clr_s;
  logic [ID_W-1:0]  win_id_s;
  logic [ID_W-1:0]  sel_id_s;
  logic             take_s;
  logic             ret_s;
  logic             irq_s;
  logic             irq_ret_s;
  logic [N_IRQ-1:0] irq_ack_s;
  logic [31:0]      irq_cause_s;

  function automatic logic [N_IRQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] oh;
    for (int k = 0; k < N_IRQ; k++) begin
      oh[k] = (id == ID_W'(k));
    end
    return oh;
  endfunction

  // Edge detection, pending latches and effective per-line requests.
  always_comb begin
    req_d  = bus.irq_req_i;
    // req_q resets to 0, so a line already high at reset release is a rising edge.
    rise_s = bus.irq_req_i & ~req_q;
    eff_s  = (EDGE_MASK & pend_q) | (~EDGE_MASK & bus.irq_req_i);
    cand_s = eff_s & bus.irq_mask_i;
    // Set is ORed in after the clear so a new edge in the take cycle is kept.
    pend_d = (pend_q & ~clr_s) | (rise_s & EDGE_MASK);
  end

  // Fixed-priority arbiter: scan downwards so the lowest set index is last written.
  always_comb begin
    win_id_s = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      win_id_s = cand_s[k] ? ID_W'(k) : win_id_s;
    end
  end

  // Trap state machine: next state, take/return decisions and captured line id.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    take_s  = 1'b0;
    ret_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.exception_i) begin
          state_d = ST_EXC;
        end else if (bus.mie_i && (|cand_s)) begin
          take_s  = 1'b1;
          id_d    = win_id_s;
          state_d = ST_IRQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IRQ: begin
        // An exception in the handler wins over a coincident MRET.
        if (bus.exception_i) begin
          state_d = ST_IRQ_EXC;
        end else if (bus.mret_i) begin
          ret_s   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IRQ;
        end
      end
      ST_EXC: begin
        if (bus.exception_i) begin
          state_d = ST_EXC;
        end else if (bus.mret_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXC;
        end
      end
      ST_IRQ_EXC: begin
        if (bus.mret_i && !bus.exception_i) begin
          state_d = ST_IRQ;
        end else begin
          state_d = ST_IRQ_EXC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; gated by reset so outputs drop as soon as rst_i rises.
  always_comb begin
    irq_s     = take_s & ~rst_i;
    irq_ret_s = ret_s & ~rst_i;
    clr_s     = irq_s ? (id_to_onehot(win_id_s) & EDGE_MASK) : '0;
    irq_ack_s = irq_ret_s ? id_to_onehot(id_q) : '0;
    // In the take cycle id_q is not yet loaded, so report the arbiter winner.
    sel_id_s  = irq_s ? win_id_s : id_q;
    irq_cause_s = {1'b1, 31'(CAUSE_BASE) + 31'(sel_id_s)};
  end

  assign bus.irq_o       = irq_s;
  assign bus.irq_ret_o   = irq_ret_s;
  assign bus.irq_ack_o   = irq_ack_s;
  assign bus.irq_cause_o = irq_cause_s;

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      req_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Self-checking bench for irq_controller_multi (N_IRQ=16, line 5 edge mode,
// CAUSE_BASE=16). Stimulus pushes expected take/return events with the cycle
// they must appear in; a negedge monitor pops and compares them whenever the
// DUT presents irq_o or irq_ret_o, and flags unexpected or missing events.
module tb_irq_controller_multi;

  localparam int N = 16;

  logic clk_i;
  logic rst_i;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    bit          is_ret;
    logic [31:0] cause;
    logic [15:0] ack;
    int          at;
  } ev_t;

  ev_t exp_q[$];

  irq_controller_multi_if #(.N_IRQ(N)) bus ();

  irq_controller_multi #(
    .N_IRQ      (N),
    .EDGE_MASK  (16'h0020),
    .CAUSE_BASE (16)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void push_ev(input bit is_ret, input logic [31:0] cause,
                                  input logic [15:0] ack, input int at);
    ev_t e;
    e.is_ret = is_ret;
    e.cause  = cause;
    e.ack    = ack;
    e.at     = at;
    exp_q.push_back(e);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare every presented event against the scoreboard.
  always @(negedge clk_i) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: ret=%0b cause=0x%08h expected at cycle %0d, not seen",
               exp_q[0].is_ret, exp_q[0].cause, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (!rst_i && (bus.irq_o === 1'b1 || bus.irq_ret_o === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d irq=%0b ret=%0b cause=0x%08h ack=0x%04h, expected none",
                 cyc, bus.irq_o, bus.irq_ret_o, bus.irq_cause_o, bus.irq_ack_o);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_ret !== bus.irq_ret_o || e.cause !== bus.irq_cause_o ||
            e.ack !== bus.irq_ack_o || e.at != cyc) begin
          errors++;
          $display("FAIL event: cycle %0d ret=%0b cause=0x%08h ack=0x%04h, expected cycle %0d ret=%0b cause=0x%08h ack=0x%04h",
                   cyc, bus.irq_ret_o, bus.irq_cause_o, bus.irq_ack_o,
                   e.at, e.is_ret, e.cause, e.ack);
        end
      end
    end
  end

  initial begin
    cyc             = 0;
    checks          = 0;
    errors          = 0;
    rst_i           = 1'b1;
    bus.exception_i = 1'b0;
    bus.irq_req_i   = 16'h0000;
    bus.irq_mask_i  = 16'hFFFF;
    bus.mie_i       = 1'b1;
    bus.mret_i      = 1'b0;
    #1;
    check32("reset_irq",   {31'd0, bus.irq_o},     32'd0);
    check32("reset_ret",   {31'd0, bus.irq_ret_o}, 32'd0);
    check32("reset_ack",   {16'd0, bus.irq_ack_o}, 32'd0);
    check32("reset_cause", bus.irq_cause_o,        32'h8000_0010);
    step();
    rst_i = 1'b0;
    step();

    // Level line 3: same-cycle take, return acks line 3.
    bus.irq_req_i = 16'h0008; push_ev(1'b0, 32'h8000_0013, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0000;
    check32("cause_hold_l3", bus.irq_cause_o, 32'h8000_0013);
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0013, 16'h0008, cyc);
    step(); bus.mret_i = 1'b0;
    step();

    // Lines 2 and 7 together: 2 wins, 7 taken the cycle after return.
    bus.irq_req_i = 16'h0084; push_ev(1'b0, 32'h8000_0012, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0080;
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0012, 16'h0004, cyc);
    step(); bus.mret_i = 1'b0; push_ev(1'b0, 32'h8000_0017, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0000;
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0017, 16'h0080, cyc);
    step(); bus.mret_i = 1'b0;
    step();

    // Edge line 5: pulse while mie=0, pending survives until mie rises.
    bus.mie_i = 1'b0; bus.irq_req_i = 16'h0020;
    step(); bus.irq_req_i = 16'h0000;
    repeat (10) step();
    bus.mie_i = 1'b1; push_ev(1'b0, 32'h8000_0015, 16'h0000, cyc);
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0015, 16'h0020, cyc);
    step(); bus.mret_i = 1'b0;
    repeat (3) step();

    // Exception (with coincident MRET) inside handler: first MRET only leaves it.
    bus.irq_req_i = 16'h0010; push_ev(1'b0, 32'h8000_0014, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0000; bus.exception_i = 1'b1; bus.mret_i = 1'b1;
    step(); bus.exception_i = 1'b0; bus.mret_i = 1'b1;
    step(); bus.mret_i = 1'b0;
    check32("cause_hold_l4", bus.irq_cause_o, 32'h8000_0014);
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0014, 16'h0010, cyc);
    step(); bus.mret_i = 1'b0;
    step();

    // Exception beats line 0 in IDLE; line 0 taken after exception return.
    bus.exception_i = 1'b1; bus.irq_req_i = 16'h0001;
    step(); bus.exception_i = 1'b0; bus.mret_i = 1'b1;
    step(); bus.mret_i = 1'b0; push_ev(1'b0, 32'h8000_0010, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0000;
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0010, 16'h0001, cyc);
    step(); bus.mret_i = 1'b0;
    step();

    // Reset mid-handler with an edge pending on line 5.
    bus.irq_req_i = 16'h0002; push_ev(1'b0, 32'h8000_0011, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0022;
    step(); bus.irq_req_i = 16'h0002;
    #2; bus.mret_i = 1'b1; rst_i = 1'b1;
    #1;
    check32("midrst_irq",   {31'd0, bus.irq_o},     32'd0);
    check32("midrst_ret",   {31'd0, bus.irq_ret_o}, 32'd0);
    check32("midrst_ack",   {16'd0, bus.irq_ack_o}, 32'd0);
    check32("midrst_cause", bus.irq_cause_o,        32'h8000_0010);
    step(); rst_i = 1'b0; bus.mret_i = 1'b0; push_ev(1'b0, 32'h8000_0011, 16'h0000, cyc);
    step(); bus.irq_req_i = 16'h0000;
    step(); bus.mret_i = 1'b1; push_ev(1'b1, 32'h8000_0011, 16'h0002, cyc);
    step(); bus.mret_i = 1'b0;
    repeat (4) step();

    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
